// File: rtl/usb_rx_bit_recovery.sv
// USB receive bit recovery: edge-resynchronised phase counter, mid-bit sampling,
// NRZI decode, bit destuffing and per-byte bit counting.
module usb_rx_bit_recovery #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       d_plus_sync,
    input  logic       d_edge,
    output logic       shift_enable,
    output logic       d_orig,
    output logic       stuff_bit,
    output logic       stuff_err,
    output logic       byte_received,
    output logic [2:0] bit_count
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_POINT);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);

    logic [PW-1:0] phase;
    logic [OW-1:0] ones_cnt;
    logic          prev_sample;
    logic          sample_evt;
    logic          rx_bit;
    logic          at_limit;

    // Sampling looks at the current phase, so an edge in the sample cycle still samples.
    assign sample_evt = enable && (phase == PH_SAMPLE);
    assign rx_bit     = (d_plus_sync == prev_sample);
    assign at_limit   = (ones_cnt == ONES_MAX);

    always_ff @(posedge clk) begin
        if (!n_rst || !enable) begin
            phase         <= '0;
            ones_cnt      <= '0;
            prev_sample   <= 1'b1;
            shift_enable  <= 1'b0;
            d_orig        <= 1'b0;
            stuff_bit     <= 1'b0;
            stuff_err     <= 1'b0;
            byte_received <= 1'b0;
            bit_count     <= 3'd0;
        end else begin
            shift_enable  <= 1'b0;
            stuff_bit     <= 1'b0;
            byte_received <= 1'b0;

            if (d_edge)
                phase <= PW'(1);
            else if (phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + PW'(1);

            if (sample_evt) begin
                prev_sample <= d_plus_sync;
                if (at_limit) begin
                    // Bit after a full run of ones must be a stuffed zero.
                    ones_cnt <= '0;
                    if (rx_bit)
                        stuff_err <= 1'b1;
                    else
                        stuff_bit <= 1'b1;
                end else begin
                    shift_enable  <= 1'b1;
                    d_orig        <= rx_bit;
                    ones_cnt      <= rx_bit ? (ones_cnt + OW'(1)) : '0;
                    bit_count     <= bit_count + 3'd1;
                    byte_received <= (bit_count == 3'd7);
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Directed bench for usb_rx_bit_recovery: one table row per USB line bit, with
// the expected pulses inside that bit window and the bit count at its end.
module tb_usb_rx_bit_recovery;

    logic       clk;
    logic       n_rst;
    logic       enable;
    logic       d_plus_sync;
    logic       d_edge;
    logic       shift_enable;
    logic       d_orig;
    logic       stuff_bit;
    logic       stuff_err;
    logic       byte_received;
    logic [2:0] bit_count;

    usb_rx_bit_recovery #(
        .CLKS_PER_BIT(8),
        .SAMPLE_POINT(3),
        .STUFF_LEN(6)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .enable(enable),
        .d_plus_sync(d_plus_sync),
        .d_edge(d_edge),
        .shift_enable(shift_enable),
        .d_orig(d_orig),
        .stuff_bit(stuff_bit),
        .stuff_err(stuff_err),
        .byte_received(byte_received),
        .bit_count(bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int level;   // line level for this bit (1 = J)
        int nclk;    // bit length in clocks
        int se;      // shift_enable pulses expected in window
        int d;       // d_orig at the shift_enable pulse
        int sb;      // stuff_bit pulses expected
        int byt;     // byte_received pulses expected
        int cnt;     // bit_count at window end
        int err;     // stuff_err at window end
        int off;     // window cycle of first pulse / stuff_err rise, -1 none
        int restart; // two idle cycles (enable=0) before this bit
    } vec_t;

    vec_t vt[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cur_level = 1;

    function automatic vec_t mk(int lvl, int n, int se, int d, int sb, int byt,
                                int cnt, int err, int off, int rs);
        vec_t v;
        v.level = lvl; v.nclk = n; v.se = se; v.d = d; v.sb = sb;
        v.byt = byt; v.cnt = cnt; v.err = err; v.off = off; v.restart = rs;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_cycle(input string tag);
        enable      = 1'b0;
        d_edge      = (cur_level != 1);
        d_plus_sync = 1'b1;
        cur_level   = 1;
        @(posedge clk); @(negedge clk);
        chk({tag, "_idle_outs"},
            int'({shift_enable, stuff_bit, stuff_err, byte_received, bit_count, d_orig}), 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        int   se_n, sb_n, by_n, by_bad, off;
        int   d_seen;
        logic err_prev;
        string tag;
        tag = $sformatf("row%0d", idx);
        se_n = 0; sb_n = 0; by_n = 0; by_bad = 0; off = -1; d_seen = -1;
        if (v.restart != 0) begin
            idle_cycle(tag);
            idle_cycle(tag);
        end
        err_prev = stuff_err;
        enable   = 1'b1;
        for (int i = 0; i < v.nclk; i++) begin
            d_edge      = (i == 0) && (v.level != cur_level);
            d_plus_sync = v.level[0];
            @(posedge clk); @(negedge clk);
            if (shift_enable) begin se_n++; d_seen = int'(d_orig); end
            if (stuff_bit) sb_n++;
            if (byte_received) by_n++;
            if (byte_received && !shift_enable) by_bad++;
            if (off < 0 && (shift_enable || stuff_bit || (stuff_err && !err_prev)))
                off = i;
            err_prev = stuff_err;
        end
        cur_level = v.level;
        chk({tag, "_shift_enable_pulses"}, se_n, v.se);
        chk({tag, "_stuff_bit_pulses"}, sb_n, v.sb);
        chk({tag, "_byte_received_pulses"}, by_n, v.byt);
        chk({tag, "_byte_without_shift"}, by_bad, 0);
        chk({tag, "_bit_count"}, int'(bit_count), v.cnt);
        chk({tag, "_stuff_err"}, int'(stuff_err), v.err);
        chk({tag, "_pulse_offset"}, off, v.off);
        if (v.se == 1) chk({tag, "_d_orig"}, d_seen, v.d);
    endtask

    // Sync pattern KJKJKJKK decodes to 0000_0001.
    task automatic add_sync(input int drift, input int rs);
        int lv[8] = '{0, 1, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            int len;
            int off;
            len = (drift != 0) ? ((i % 2 == 0) ? 7 : 9) : 8;
            off = (i == 7 && drift != 0) ? 4 : 3;
            vt.push_back(mk(lv[i], len, 1, (i == 7) ? 1 : 0, 0, (i == 7) ? 1 : 0,
                            (i + 1) % 8, 0, off, (i == 0) ? rs : 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; enable = 1'b1; d_plus_sync = 1'b1; d_edge = 1'b0;

        // Reset held with a busy line.
        for (int i = 0; i < 2; i++) begin
            d_plus_sync = ~d_plus_sync; d_edge = 1'b1;
            @(posedge clk); @(negedge clk);
            chk($sformatf("reset_outs_%0d", i),
                int'({shift_enable, d_orig, stuff_bit, stuff_err, byte_received, bit_count}), 0);
        end
        n_rst = 1'b1;
        d_plus_sync = ~d_plus_sync; d_edge = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_reset_outs",
            int'({shift_enable, d_orig, stuff_bit, stuff_err, byte_received, bit_count}), 0);
        cur_level = int'(d_plus_sync);

        add_sync(0, 1);                 // nominal sync byte
        add_sync(1, 1);                 // 7/9 clock drift

        // Stuffing: 0, six 1s, stuffed 0, data 0.
        vt.push_back(mk(0, 8, 1, 0, 0, 0, 1, 0, 3, 1));
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(0, 8, 1, 1, 0, 0, i + 2, 0, 3, 0));
        vt.push_back(mk(1, 8, 0, 0, 1, 0, 7, 0, 3, 0));
        vt.push_back(mk(0, 8, 1, 0, 0, 1, 0, 0, 3, 0));

        // Violation: 0, six 1s, seventh 1 is an error, next 1 is data again.
        vt.push_back(mk(0, 8, 1, 0, 0, 0, 1, 0, 3, 1));
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(0, 8, 1, 1, 0, 0, i + 2, 0, 3, 0));
        vt.push_back(mk(0, 8, 0, 0, 0, 0, 7, 1, 3, 0));
        vt.push_back(mk(0, 8, 1, 1, 0, 1, 0, 1, 3, 0));

        // Abort after three bits, then a fresh sync byte.
        vt.push_back(mk(0, 8, 1, 0, 0, 0, 1, 0, 3, 1));
        vt.push_back(mk(1, 8, 1, 0, 0, 0, 2, 0, 3, 0));
        vt.push_back(mk(0, 8, 1, 0, 0, 0, 3, 0, 3, 0));
        add_sync(0, 1);

        for (int i = 0; i < vt.size(); i++)
            apply(vt[i], i);

        idle_cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
